// File: rtl/uart_sha_msg_loader_pkg.sv
// Shared state type, digest/display widths and the digest window helper
// for the UART-to-SHA-256 message loader.
package uart_sha_pkg;

   typedef enum logic [1:0] {COLLECT, SEND, WAIT_HASH, SHOW} state_t;

   localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h0D;
   localparam int         DIGEST_W          = 256;
   localparam int         DISP_W            = 24;
   localparam int         NUM_WINDOWS       = (DIGEST_W + DISP_W - 1) / DISP_W;

   // Window k covers digest bits [24k+23:24k]; bits past the digest top read as zero.
   function automatic logic [DISP_W-1:0] hash_window(input logic [DIGEST_W-1:0] hash,
                                                     input logic [3:0]          sel);
      logic [DIGEST_W-1:0] shifted;
      shifted = hash >> (DISP_W * int'(sel));
      if (int'(sel) >= NUM_WINDOWS) begin
         return '0;
      end
      return shifted[DISP_W-1:0];
   endfunction

endpackage

// File: rtl/uart_sha_msg_loader_buf.sv
// Message byte store: MAX_BYTES x 8 register file with an append-style write
// port, one asynchronous read port, a length clear and a last-three-bytes tap.
module msg_buffer
   import uart_sha_pkg::*;
#(
   parameter  int MAX_BYTES = 55,
   localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              clr,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [7:0]        rd_data,
   output logic [LEN_W-1:0]  len,
   output logic              full,
   output logic [DISP_W-1:0] tail
);

   logic [7:0]       mem [MAX_BYTES];
   logic [LEN_W-1:0] len_reg;
   logic             store;

   assign full  = (len_reg == LEN_W'(MAX_BYTES));
   assign store = wr_en && !full && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_reg <= '0;
      end else if (clr) begin
         len_reg <= '0;
      end else if (store) begin
         len_reg <= len_reg + LEN_W'(1);
      end
   end

   // Contents need no reset: every read path is qualified by len.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[len_reg] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];
   assign len     = len_reg;

   for (genvar gi = 0; gi < 3; gi++) begin : g_tail
      assign tail[8*gi +: 8] = (len_reg > LEN_W'(gi)) ? mem[len_reg - LEN_W'(gi + 1)] : 8'h00;
   end

endmodule

// File: rtl/uart_sha_msg_loader.sv
// Collects UART RX bytes into a message, streams it to the SHA-256 core and shows
// a digest window. Optional WAIT_HASH watchdog: define UART_SHA_MSG_LOADER_TIMEOUT_EN.
module uart_sha_msg_loader
   import uart_sha_pkg::*;
#(
   parameter  int         MAX_BYTES   = 55,
   parameter  logic [7:0] TERM_BYTE   = DEFAULT_TERM_BYTE,
   parameter  int         TIMEOUT_CYC = 1024,
   localparam int         LEN_W       = $clog2(MAX_BYTES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_empty_i,
   input  logic [7:0]          rx_data_i,
   output logic                rd_uart_o,
   input  logic                start_i,
   input  logic [3:0]          disp_sel_i,
   output logic [7:0]          sha_data_o,
   output logic                sha_valid_o,
   output logic                sha_last_o,
   input  logic                sha_ready_i,
   input  logic                sha_done_i,
   input  logic [DIGEST_W-1:0] hash_i,
   output logic [DISP_W-1:0]   disp_o,
   output logic [LEN_W-1:0]    msg_len_o,
   output logic                overflow_o,
`ifdef UART_SHA_MSG_LOADER_TIMEOUT_EN
   output logic                busy_o,
   output logic                timeout_o
`else
   output logic                busy_o
`endif
);

   if (MAX_BYTES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("uart_sha_msg_loader: MAX_BYTES and TIMEOUT_CYC must be positive");
   end

   state_t              state_reg, state_next;
   logic [LEN_W-1:0]    idx_reg;
   logic [DIGEST_W-1:0] hash_reg;
   logic                overflow_reg;
   logic                pop, buf_we, buf_clr, idx_clr, idx_inc, hash_ld, ovf_set, ovf_clr;
   logic                tmo_fire;
   logic                buf_full;
   logic [LEN_W-1:0]    len;
   logic [7:0]          buf_rd;
   logic [DISP_W-1:0]   buf_tail;

   msg_buffer #(.MAX_BYTES(MAX_BYTES)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_we),
      .wr_data (rx_data_i),
      .clr     (buf_clr),
      .rd_addr (idx_reg),
      .rd_data (buf_rd),
      .len     (len),
      .full    (buf_full),
      .tail    (buf_tail)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= COLLECT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pop        = 1'b0;
      buf_we     = 1'b0;
      buf_clr    = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      hash_ld    = 1'b0;
      ovf_set    = 1'b0;
      ovf_clr    = 1'b0;
      case (state_reg)
         COLLECT: begin
            // start_i suppresses the pop so a pending byte stays for the next message
            if (start_i) begin
               if (len != '0) begin
                  state_next = SEND;
                  idx_clr    = 1'b1;
               end
            end else if (!rx_empty_i) begin
               pop = 1'b1;
               if (rx_data_i == TERM_BYTE) begin
                  if (len != '0) begin
                     state_next = SEND;
                     idx_clr    = 1'b1;
                  end
               end else if (buf_full) begin
                  ovf_set = 1'b1;
               end else begin
                  buf_we = 1'b1;
               end
            end
         end
         SEND: begin
            if (sha_ready_i) begin
               idx_inc = 1'b1;
               if (idx_reg == len - LEN_W'(1)) begin
                  state_next = WAIT_HASH;
               end
            end
         end
         WAIT_HASH: begin
            if (sha_done_i) begin
               hash_ld    = 1'b1;
               state_next = SHOW;
            end else if (tmo_fire) begin
               state_next = COLLECT;
            end
         end
         SHOW: begin
            if (start_i) begin
               state_next = SEND;
               idx_clr    = 1'b1;
            end else if (!rx_empty_i) begin
               state_next = COLLECT;
               buf_clr    = 1'b1;
               idx_clr    = 1'b1;
               ovf_clr    = 1'b1;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg      <= '0;
         hash_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (idx_clr) begin
            idx_reg <= '0;
         end else if (idx_inc) begin
            idx_reg <= idx_reg + LEN_W'(1);
         end
         if (hash_ld) begin
            hash_reg <= hash_i;
         end else if (tmo_fire) begin
            hash_reg <= '0;
         end
         if (ovf_clr) begin
            overflow_reg <= 1'b0;
         end else if (ovf_set) begin
            overflow_reg <= 1'b1;
         end
      end
   end

`ifdef UART_SHA_MSG_LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             timeout_reg;

   assign tmo_fire = (state_reg == WAIT_HASH) && !sha_done_i &&
                     (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_reg <= '0;
         timeout_reg <= 1'b0;
      end else begin
         tmo_cnt_reg <= (state_reg == WAIT_HASH && !tmo_fire) ? tmo_cnt_reg + TMO_W'(1) : '0;
         if (tmo_fire) begin
            timeout_reg <= 1'b1;
         end else if (start_i) begin
            timeout_reg <= 1'b0;
         end
      end
   end

   assign timeout_o = timeout_reg;
`else
   assign tmo_fire = 1'b0;
`endif

   // Pop is gated by rst so the FIFO is never drained while the loader is held in reset.
   assign rd_uart_o   = pop & ~rst;
   assign sha_valid_o = (state_reg == SEND);
   assign sha_data_o  = sha_valid_o ? buf_rd : 8'h00;
   assign sha_last_o  = sha_valid_o && (idx_reg == len - LEN_W'(1));
   assign busy_o      = (state_reg == SEND) || (state_reg == WAIT_HASH);
   assign disp_o      = (state_reg == SHOW) ? hash_window(hash_reg, disp_sel_i) : buf_tail;
   assign msg_len_o   = len;
   assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_uart_sha_msg_loader.sv
// Self-checking bench for uart_sha_msg_loader: FIFO and SHA core models plus a
// message-level reference (byte queues) compared against the streamed bytes.
`timescale 1ns/1ps
module tb_uart_sha_msg_loader;

   localparam int             MAX_BYTES = 55;
   localparam int             LEN_W     = $clog2(MAX_BYTES + 1);
   localparam logic [7:0]     TERM      = 8'h0D;
   localparam logic [255:0]   HASH_ABC  =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_empty_i;
   logic [7:0]       rx_data_i;
   logic             rd_uart_o;
   logic             start_i;
   logic [3:0]       disp_sel_i;
   logic [7:0]       sha_data_o;
   logic             sha_valid_o;
   logic             sha_last_o;
   logic             sha_ready_i;
   logic             sha_done_i;
   logic [255:0]     hash_i;
   logic [23:0]      disp_o;
   logic [LEN_W-1:0] msg_len_o;
   logic             overflow_o;
   logic             busy_o;
`ifdef UART_SHA_MSG_LOADER_TIMEOUT_EN
   logic             timeout_o;
`endif

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_q   [$];
   logic [7:0] popped [$];
   logic [7:0] sent   [$];
   logic       lasts  [$];
   int         send_cycles = 0;
   logic       stall_prev  = 1'b0;
   logic [7:0] stall_data  = 8'h00;

   always #5 clk = ~clk;

   uart_sha_msg_loader dut (
      .clk         (clk),
      .rst         (rst),
      .rx_empty_i  (rx_empty_i),
      .rx_data_i   (rx_data_i),
      .rd_uart_o   (rd_uart_o),
      .start_i     (start_i),
      .disp_sel_i  (disp_sel_i),
      .sha_data_o  (sha_data_o),
      .sha_valid_o (sha_valid_o),
      .sha_last_o  (sha_last_o),
      .sha_ready_i (sha_ready_i),
      .sha_done_i  (sha_done_i),
      .hash_i      (hash_i),
      .disp_o      (disp_o),
      .msg_len_o   (msg_len_o),
      .overflow_o  (overflow_o),
`ifdef UART_SHA_MSG_LOADER_TIMEOUT_EN
      .busy_o      (busy_o),
      .timeout_o   (timeout_o)
`else
      .busy_o      (busy_o)
`endif
   );

   // ---------------- models ----------------
   function automatic logic [7:0] rand_byte();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == TERM) b = 8'h5A;
      return b;
   endfunction

   // Digest window built bit by bit: bit b of window k is digest bit 24k+b if it exists.
   function automatic logic [23:0] exp_window(input logic [255:0] h, input int k);
      logic [23:0] w;
      w = '0;
      if (k < 11) begin
         for (int b = 0; b < 24; b++) begin
            if (24 * k + b < 256) w[b] = h[24 * k + b];
         end
      end
      return w;
   endfunction

   // -1 when the captured stream equals exp with last flagged only on the final byte.
   function automatic int stream_diff(input logic [7:0] exp [$]);
      if (sent.size() != exp.size()) return 1000 + sent.size();
      for (int i = 0; i < exp.size(); i++) begin
         if (sent[i] !== exp[i]) return i;
         if (lasts[i] !== (i == exp.size() - 1)) return i;
      end
      return -1;
   endfunction

   task automatic refresh_rx();
      rx_empty_i = (rx_q.size() == 0);
      rx_data_i  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
   endtask

   // One clock: sample at the falling edge, let the FIFO pop at the rising edge.
   task automatic tick();
      logic pop;
      @(negedge clk);
      pop = rd_uart_o;
      if (pop) popped.push_back(rx_data_i);
      if (sha_valid_o && stall_prev) begin
         checks++;
         if (sha_data_o !== stall_data) begin
            errors++;
            $display("FAIL hold_stable: sha_data_o=%h required %h", sha_data_o, stall_data);
         end
      end
      stall_prev = sha_valid_o && !sha_ready_i;
      stall_data = sha_data_o;
      if (sha_valid_o) send_cycles++;
      if (sha_valid_o && sha_ready_i) begin
         sent.push_back(sha_data_o);
         lasts.push_back(sha_last_o);
      end
      @(posedge clk);
      if (pop && rx_q.size() > 0) rx_q.delete(0);
      #1;
      refresh_rx();
   endtask

   // Advance until WAIT_HASH; mode 0 ready high, 1 pattern 1,0,0,1, 2 random ready.
   task automatic run_until_wait(input int mode, input int bound);
      logic rdy_pat [4];
      int   i;
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      sent.delete();
      lasts.delete();
      send_cycles = 0;
      i = 0;
      while (!(busy_o && !sha_valid_o) && i < bound) begin
         if (mode == 0)      sha_ready_i = 1'b1;
         else if (mode == 1) sha_ready_i = rdy_pat[i % 4];
         else                sha_ready_i = 1'($urandom_range(0, 1));
         tick();
         i++;
      end
      sha_ready_i = 1'b1;
      checks++;
      if (i >= bound) begin
         errors++;
         $display("FAIL wait_hash_reached: cycles=%0d required <%0d", i, bound);
      end
   endtask

   task automatic give_done(input logic [255:0] h);
      sha_done_i = 1'b1;
      hash_i     = h;
      tick();
      sha_done_i = 1'b0;
      hash_i     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL show_not_busy: busy_o=%b required 0", busy_o);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      rx_q.delete();
      refresh_rx();
      start_i = 0; disp_sel_i = 0; sha_ready_i = 1; sha_done_i = 0; hash_i = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rd_uart_o, sha_valid_o, sha_last_o, busy_o, overflow_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 00000",
                  {rd_uart_o, sha_valid_o, sha_last_o, busy_o, overflow_o});
      end
      checks++;
      if (disp_o !== 24'h0 || msg_len_o !== '0 || sha_data_o !== 8'h0) begin
         errors++;
         $display("FAIL reset_values: disp=%h len=%0d data=%h required 0", disp_o, msg_len_o, sha_data_o);
      end
      rst = 1'b0;
      tick();
      $display("reset: released");
   endtask

   task automatic test_term_empty();
      popped.delete();
      rx_q.push_back(TERM);
      refresh_rx();
      tick();
      checks++;
      if (popped.size() != 1 || rx_q.size() != 0) begin
         errors++;
         $display("FAIL term_empty_pop: popped=%0d required 1", popped.size());
      end
      checks++;
      if (busy_o !== 1'b0 || sha_valid_o !== 1'b0 || msg_len_o !== '0) begin
         errors++;
         $display("FAIL term_empty_stay: busy=%b valid=%b len=%0d required 0,0,0",
                  busy_o, sha_valid_o, msg_len_o);
      end
      sha_done_i = 1'b1;
      hash_i     = HASH_ABC;
      tick();
      sha_done_i = 1'b0;
      disp_sel_i = 4'd0;
      #1;
      checks++;
      if (disp_o !== 24'h0) begin
         errors++;
         $display("FAIL done_ignored: disp_o=%h required 000000", disp_o);
      end
      $display("term_empty: terminator discarded, stray done ignored");
   endtask

   task automatic test_basic();
      logic [7:0] exp [$];
      int         n;
      exp = '{8'h61, 8'h62, 8'h63};
      popped.delete();
      foreach (exp[i]) rx_q.push_back(exp[i]);
      rx_q.push_back(TERM);
      refresh_rx();
      sha_ready_i = 1'b1;
      n = 0;
      while (popped.size() < 4 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (popped.size() != 4 || n != 4) begin
         errors++;
         $display("FAIL basic_pops: popped=%0d cycles=%0d required 4,4", popped.size(), n);
      end
      checks++;
      if (sha_valid_o !== 1'b1 || sha_data_o !== 8'h61 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_latency: valid=%b data=%h busy=%b required 1,61,1",
                  sha_valid_o, sha_data_o, busy_o);
      end
      checks++;
      if (disp_o !== 24'h616263 || msg_len_o !== LEN_W'(3)) begin
         errors++;
         $display("FAIL basic_tail: disp=%h len=%0d required 616263,3", disp_o, msg_len_o);
      end
      run_until_wait(0, 20);
      checks++;
      if (stream_diff(exp) != -1 || send_cycles != 3) begin
         errors++;
         $display("FAIL basic_stream: diff=%0d cycles=%0d required -1,3", stream_diff(exp), send_cycles);
      end
      checks++;
      if (sha_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_wait: valid=%b busy=%b required 0,1", sha_valid_o, busy_o);
      end
      give_done(HASH_ABC);
      for (int k = 0; k < 16; k++) begin
         disp_sel_i = 4'(k);
         #1;
         checks++;
         if (disp_o !== exp_window(HASH_ABC, k)) begin
            errors++;
            $display("FAIL window_sel%0d: disp_o=%h required %h", k, disp_o, exp_window(HASH_ABC, k));
         end
      end
      disp_sel_i = 4'd0;
      #1;
      checks++;
      if (disp_o !== 24'h0015AD) begin
         errors++;
         $display("FAIL window_abc0: disp_o=%h required 0015ad", disp_o);
      end
      $display("basic: msg 616263 len=3 streamed in %0d cycles", send_cycles);
   endtask

   task automatic test_ready_toggle();
      logic [7:0] exp [$];
      int         len;
      len = $urandom_range(4, 10);
      for (int i = 0; i < len; i++) exp.push_back(rand_byte());
      foreach (exp[i]) rx_q.push_back(exp[i]);
      rx_q.push_back(TERM);
      refresh_rx();
      run_until_wait(1, 100);
      checks++;
      if (stream_diff(exp) != -1) begin
         errors++;
         $display("FAIL toggle_stream: diff=%0d sent=%0d required -1 for len %0d",
                  stream_diff(exp), sent.size(), len);
      end
      give_done({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      $display("ready_toggle: len=%0d sent=%0d valid_cycles=%0d", len, sent.size(), send_cycles);
   endtask

   task automatic test_overflow();
      logic [7:0] all [$];
      logic [7:0] exp [$];
      logic [7:0] x;
      int         n;
      for (int i = 0; i < MAX_BYTES + 2; i++) all.push_back(rand_byte());
      for (int i = 0; i < MAX_BYTES; i++) exp.push_back(all[i]);
      foreach (all[i]) rx_q.push_back(all[i]);
      refresh_rx();
      n = 0;
      while (rx_q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (msg_len_o !== LEN_W'(MAX_BYTES) || overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_saturate: len=%0d ovf=%b required %0d,1", msg_len_o, overflow_o, MAX_BYTES);
      end
      checks++;
      if (disp_o !== {all[MAX_BYTES-3], all[MAX_BYTES-2], all[MAX_BYTES-1]}) begin
         errors++;
         $display("FAIL ovf_tail: disp=%h required %h", disp_o,
                  {all[MAX_BYTES-3], all[MAX_BYTES-2], all[MAX_BYTES-1]});
      end
      rx_q.push_back(TERM);
      refresh_rx();
      run_until_wait(2, 400);
      checks++;
      if (stream_diff(exp) != -1) begin
         errors++;
         $display("FAIL ovf_stream: diff=%0d sent=%0d required -1", stream_diff(exp), sent.size());
      end
      give_done(HASH_ABC);
      checks++;
      if (overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: overflow_o=%b required 1", overflow_o);
      end
      x = rand_byte();
      rx_q.push_back(x);
      refresh_rx();
      tick();
      checks++;
      if (overflow_o !== 1'b0 || msg_len_o !== '0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b len=%0d required 0,0", overflow_o, msg_len_o);
      end
      tick();
      checks++;
      if (msg_len_o !== LEN_W'(1) || disp_o !== {16'h0, x}) begin
         errors++;
         $display("FAIL ovf_first_byte: len=%0d disp=%h required 1,%h", msg_len_o, disp_o, {16'h0, x});
      end
      $display("overflow: pushed %0d, stored %0d, streamed %0d", all.size(), exp.size(), sent.size());
   endtask

   task automatic test_start_priority();
      logic [7:0] exp [$];
      logic [7:0] y;
      exp.push_back(disp_o[7:0]);
      y = rand_byte();
      rx_q.push_back(y);
      refresh_rx();
      start_i = 1'b1;
      #1;
      checks++;
      if (rd_uart_o !== 1'b0) begin
         errors++;
         $display("FAIL start_no_pop: rd_uart_o=%b required 0", rd_uart_o);
      end
      tick();
      start_i = 1'b0;
      checks++;
      if (sha_valid_o !== 1'b1 || rx_q.size() != 1) begin
         errors++;
         $display("FAIL start_send: valid=%b fifo=%0d required 1,1", sha_valid_o, rx_q.size());
      end
      run_until_wait(0, 20);
      checks++;
      if (stream_diff(exp) != -1) begin
         errors++;
         $display("FAIL start_stream: diff=%0d required -1", stream_diff(exp));
      end
      give_done(HASH_ABC);
      popped.delete();
      tick();
      tick();
      checks++;
      if (popped.size() != 1 || msg_len_o !== LEN_W'(1) || disp_o !== {16'h0, y}) begin
         errors++;
         $display("FAIL start_byte_kept: popped=%0d len=%0d disp=%h required 1,1,%h",
                  popped.size(), msg_len_o, disp_o, {16'h0, y});
      end
      $display("start_priority: pending byte %h kept for next message", y);
   endtask

   task automatic test_replay();
      logic [7:0] exp [$];
      int         first;
      exp.push_back(disp_o[7:0]);
      for (int i = 0; i < 3; i++) exp.push_back(rand_byte());
      for (int i = 1; i < 4; i++) rx_q.push_back(exp[i]);
      rx_q.push_back(TERM);
      refresh_rx();
      run_until_wait(2, 100);
      first = stream_diff(exp);
      checks++;
      if (first != -1) begin
         errors++;
         $display("FAIL replay_first: diff=%0d required -1", first);
      end
      give_done(HASH_ABC);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checks++;
      if (sha_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL replay_send: valid=%b required 1", sha_valid_o);
      end
      run_until_wait(1, 100);
      checks++;
      if (stream_diff(exp) != -1) begin
         errors++;
         $display("FAIL replay_stream: diff=%0d required -1", stream_diff(exp));
      end
      give_done(HASH_ABC);
      $display("replay: len=%0d resent identically", exp.size());
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 4; m++) begin
         logic [7:0]   exp [$];
         logic [255:0] h;
         int           len, k;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) exp.push_back(rand_byte());
         foreach (exp[i]) rx_q.push_back(exp[i]);
         rx_q.push_back(TERM);
         refresh_rx();
         run_until_wait(m % 3, 300);
         checks++;
         if (stream_diff(exp) != -1 || msg_len_o !== LEN_W'(len) || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_msg%0d: diff=%0d len=%0d ovf=%b required -1,%0d,0",
                     m, stream_diff(exp), msg_len_o, overflow_o, len);
         end
         if (m % 3 == 0) begin
            checks++;
            if (send_cycles != len) begin
               errors++;
               $display("FAIL b2b_cycles%0d: cycles=%0d required %0d", m, send_cycles, len);
            end
         end
         h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         give_done(h);
         k = $urandom_range(0, 15);
         disp_sel_i = 4'(k);
         #1;
         checks++;
         if (disp_o !== exp_window(h, k)) begin
            errors++;
            $display("FAIL b2b_window%0d: sel=%0d disp=%h required %h", m, k, disp_o, exp_window(h, k));
         end
         $display("back_to_back %0d: len=%0d mode=%0d sel=%0d disp=%h", m, len, m % 3, k, disp_o);
      end
   endtask

   task automatic test_reset_mid_send();
      int n;
      for (int i = 0; i < 5; i++) rx_q.push_back(rand_byte());
      rx_q.push_back(TERM);
      refresh_rx();
      sha_ready_i = 1'b0;
      n = 0;
      while (sha_valid_o !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (sha_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL midsend_reach: valid=%b required 1", sha_valid_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({sha_valid_o, sha_last_o, busy_o, overflow_o, rd_uart_o} !== 5'b0 || sha_data_o !== 8'h0) begin
         errors++;
         $display("FAIL midsend_reset_flags: flags=%b data=%h required 00000,00",
                  {sha_valid_o, sha_last_o, busy_o, overflow_o, rd_uart_o}, sha_data_o);
      end
      checks++;
      if (msg_len_o !== '0 || disp_o !== 24'h0) begin
         errors++;
         $display("FAIL midsend_reset_vals: len=%0d disp=%h required 0,0", msg_len_o, disp_o);
      end
      @(posedge clk);
      #1;
      rst         = 1'b0;
      stall_prev  = 1'b0;
      sha_ready_i = 1'b1;
      $display("reset_mid_send: outputs cleared asynchronously");
   endtask

   initial begin
      test_reset();
      test_term_empty();
      test_basic();
      test_ready_toggle();
      test_overflow();
      test_start_priority();
      test_replay();
      test_back_to_back();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
